// File: rtl/mux_scan.sv
// N_CH-channel valid/ready multiplexer with manual select or round-robin dwell scanning.
// Define MUX_SCAN_PARITY_EN to register even parity of out_data on out_parity.
module mux_scan #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 8,
  parameter int DWELL = 4,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [CW-1:0]           sel,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  input  logic [N_CH-1:0]         in_valid,
  output logic [N_CH-1:0]         in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_parity
);

  typedef enum logic {DWELL_ST, ADV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cur, cur_nxt, sel_clamp;
  logic [7:0]       dcnt, dcnt_nxt;
  logic             gate_open, cur_valid, xfer;
  logic [WIDTH-1:0] cur_data;

  assign cur_valid = in_valid[cur];
  assign cur_data  = in_data[cur*WIDTH +: WIDTH];
  assign sel_clamp = (int'(sel) >= N_CH) ? CW'(N_CH - 1) : sel;

  // The active channel may hand over a beat only when the output register can
  // take it, outside reset, and never during the scan advance cycle.
  assign gate_open = rst_n && (!out_valid || out_ready) && !(mode && (state == ADV));
  assign xfer      = gate_open && cur_valid;

  always_comb begin
    in_ready = '0;
    if (gate_open) in_ready[cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DWELL_ST;
      cur   <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      cur   <= cur_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    dcnt_nxt  = dcnt;
    if (!mode) begin
      state_nxt = DWELL_ST;
      dcnt_nxt  = '0;
      cur_nxt   = sel_clamp;
    end else begin
      case (state)
        DWELL_ST: begin
          if (xfer) begin
            if (dcnt == 8'(DWELL - 1)) state_nxt = ADV;
            else                       dcnt_nxt  = dcnt + 8'd1;
          end else if (gate_open && !cur_valid) begin
            state_nxt = ADV;
          end
        end
        ADV: begin
          cur_nxt   = (cur == CW'(N_CH - 1)) ? '0 : cur + CW'(1);
          dcnt_nxt  = '0;
          state_nxt = DWELL_ST;
        end
        default: state_nxt = DWELL_ST;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_ch    <= cur;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    out_parity <= 1'b0;
    else if (xfer) out_parity <= ^cur_data;
  end
`else
  assign out_parity = 1'b0;
`endif

endmodule
